// File: rtl/apb_slave_regfile.sv
// APB4 completer backed by a word-addressed register file.
// Programmable wait states, byte strobes, decode errors and a sticky protocol-violation flag.
module apb_slave_regfile #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH       = 16,
    parameter int                    WAIT_STATES = 0,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr,
    output logic                    prot_err,
    input  logic                    prot_err_clr
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_W - 1);
    localparam logic [3:0] CNT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [3:0]              r_cnt;
    logic [3:0]              w_cnt_next;
    logic                    r_pready;
    logic                    r_pslverr;
    logic [DATA_WIDTH-1:0]   r_prdata;
    logic                    r_prot_err;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_write;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_W-1:0]       r_strb;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_err;

    logic [ADDR_WIDTH-1:0]   w_offset;
    logic [ADDR_WIDTH-1:0]   w_word;
    logic                    w_dec_err;
    logic                    w_changed;
    logic                    w_capture;
    logic                    w_viol;
    logic                    w_set_rdy;
    logic                    w_complete;
    logic                    w_abort;

    // Address decode on the live bus; only the SETUP-phase value is ever kept.
    assign w_offset  = paddr - BASE_ADDR;
    assign w_word    = w_offset >> LSB;
    assign w_dec_err = (paddr < BASE_ADDR) || (w_word >= ADDR_WIDTH'(DEPTH)) ||
                       (|(paddr & ALIGN_MASK));
    assign w_changed = (paddr != r_addr) || (pwrite != r_write) ||
                       (pwdata != r_wdata) || (pstrb != r_strb);

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_capture  = 1'b0;
        w_viol     = 1'b0;
        w_set_rdy  = 1'b0;
        w_complete = 1'b0;
        w_abort    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (psel && penable) begin
                    w_viol = 1'b1;
                end else if (psel) begin
                    w_next    = S_SETUP;
                    w_capture = 1'b1;
                end
            end
            S_SETUP: begin
                if (!psel) begin
                    w_abort    = 1'b1;
                    w_viol     = 1'b1;
                    w_cnt_next = 4'd0;
                    w_next     = S_IDLE;
                end else begin
                    w_viol = w_changed;
                    if (penable) begin
                        w_next     = S_ACCESS;
                        w_cnt_next = 4'd0;
                        w_set_rdy  = (WAIT_STATES == 0);
                    end
                end
            end
            S_ACCESS: begin
                if (!psel) begin
                    w_abort    = 1'b1;
                    w_viol     = 1'b1;
                    w_cnt_next = 4'd0;
                    w_next     = S_IDLE;
                end else begin
                    w_viol = w_changed;
                    if (r_pready) begin
                        w_complete = 1'b1;
                        w_cnt_next = 4'd0;
                        w_next     = S_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        w_set_rdy = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + 4'd1;
                    end
                end
            end
            S_DONE: begin
                // DONE observes the cycle after completion: a fresh SETUP or idle bus.
                if (psel && penable) begin
                    w_viol = 1'b1;
                    w_next = S_IDLE;
                end else if (psel) begin
                    w_next    = S_SETUP;
                    w_capture = 1'b1;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_pready   <= 1'b0;
            r_pslverr  <= 1'b0;
            r_prdata   <= '0;
            r_prot_err <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_abort || w_complete) begin
                r_pready  <= 1'b0;
                r_pslverr <= 1'b0;
                r_prdata  <= '0;
            end else if (w_set_rdy) begin
                r_pready  <= 1'b1;
                r_pslverr <= r_err;
                r_prdata  <= (r_write || r_err) ? '0 : r_mem[r_idx];
            end
            if (w_viol) begin
                r_prot_err <= 1'b1;
            end else if (prot_err_clr) begin
                r_prot_err <= 1'b0;
            end
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_complete && r_write && !r_err) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (r_strb[i]) begin
                    r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    // Transfer attributes frozen at SETUP; later bus changes only raise prot_err.
    always_ff @(posedge pclk) begin
        if (w_capture) begin
            r_addr  <= paddr;
            r_write <= pwrite;
            r_wdata <= pwdata;
            r_strb  <= pstrb;
            r_idx   <= w_word[IDX_W-1:0];
            r_err   <= w_dec_err;
        end
    end

    assign prdata   = r_prdata;
    assign pready   = r_pready;
    assign pslverr  = r_pslverr;
    assign prot_err = r_prot_err;

endmodule
